// File: rtl/red_pitaya_pfd_freq_meter_pkg.sv
// Shared definitions for the PFD frequency meter and related phase/PID blocks.
// - state_e      : frequency-meter FSM encoding (IDLE=0, PRIME=1, RUN=2)
// - phase_delta  : modular phase subtraction, reinterpreted as a signed step
// - saturate     : clamp a wide signed value to a signed field of a given width
package red_pitaya_pfd_freq_meter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2
  } state_e;

  // Working width for the generic helpers; callers cast down to their own width.
  localparam int unsigned CalcWidth = 64;

  // (cur - prev) mod 2^width as a signed value in -2^(width-1) .. 2^(width-1)-1.
  // An exact half-turn lands on the negative end.
  function automatic logic signed [CalcWidth-1:0] phase_delta(
    input logic [CalcWidth-1:0] cur,
    input logic [CalcWidth-1:0] prev,
    input int unsigned          width
  );
    logic [CalcWidth-1:0] mask;
    logic [CalcWidth-1:0] diff;
    mask = (CalcWidth'(1) << width) - CalcWidth'(1);
    diff = (cur - prev) & mask;
    if (((diff >> (width - 1)) & CalcWidth'(1)) != '0) begin
      diff = diff - (CalcWidth'(1) << width);
    end
    return signed'(diff);
  endfunction

  // Clamp x to [-2^(width-1), 2^(width-1)-1].
  function automatic logic signed [CalcWidth-1:0] saturate(
    input logic signed [CalcWidth-1:0] x,
    input int unsigned                 width
  );
    logic signed [CalcWidth-1:0] hi;
    logic signed [CalcWidth-1:0] lo;
    hi = signed'((CalcWidth'(1) << (width - 1)) - CalcWidth'(1));
    lo = -hi - CalcWidth'(signed'(1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/red_pitaya_pfd_unwrap.sv
// Phase unwrapper: holds the previous phase sample and presents the signed,
// modulo-one-turn step from it to the current sample.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (prev cleared)
//   load       : capture phase as the new reference this cycle
//   phase      : unsigned phase word (full scale = one turn)
//   delta      : signed step phase - prev, wrapped into one turn
module red_pitaya_pfd_unwrap
  import red_pitaya_pfd_freq_meter_pkg::*;
#(
  parameter int unsigned PHASEWIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [PHASEWIDTH-1:0]        phase,
  output logic signed [PHASEWIDTH-1:0] delta
);

  logic [PHASEWIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (load) begin
      prev_q <= phase;
    end
  end

  // Combinational so the step is available in the same cycle as its sample.
  always_comb begin
    delta = PHASEWIDTH'(phase_delta(CalcWidth'(phase), CalcWidth'(prev_q), PHASEWIDTH));
  end

endmodule

// File: rtl/red_pitaya_pfd_freq_meter.sv
// Frequency meter: integrates unwrapped phase steps over a programmable gate
// window and publishes the signed sum once per window.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   phase_i       : phase word from the phase detector
//   enable_i      : measurement enable; low discards any partial window
//   gate_len_i    : samples per window (0 behaves as 1), taken at window starts
//   shift_i       : arithmetic right shift used to form out_o
//   clear_i       : clears the sticky overflow flag
//   freq_o        : signed sum of steps over the last window
//   out_o         : saturated (freq >>> shift_i) for DAC/PID routing
//   valid_o       : one-cycle strobe when freq_o/out_o update
//   overflow_o    : sticky accumulator saturation flag
module red_pitaya_pfd_freq_meter
  import red_pitaya_pfd_freq_meter_pkg::*;
#(
  parameter int unsigned PHASEWIDTH = 12,
  parameter int unsigned GATEWIDTH  = 24,
  parameter int unsigned ACCWIDTH   = 32,
  parameter int unsigned SIGNALBITS = 14
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [PHASEWIDTH-1:0]        phase_i,
  input  logic                         enable_i,
  input  logic [GATEWIDTH-1:0]         gate_len_i,
  input  logic [4:0]                   shift_i,
  input  logic                         clear_i,
  output logic signed [ACCWIDTH-1:0]   freq_o,
  output logic signed [SIGNALBITS-1:0] out_o,
  output logic                         valid_o,
  output logic                         overflow_o
);

  state_e state_q, state_d;

  logic signed [ACCWIDTH-1:0]   acc_q, acc_d;
  logic signed [ACCWIDTH-1:0]   freq_q, freq_d;
  logic signed [SIGNALBITS-1:0] out_q, out_d;
  logic [GATEWIDTH-1:0]         cnt_q, cnt_d;
  logic [GATEWIDTH-1:0]         len_q, len_d;
  logic                         valid_q, valid_d;
  logic                         ovf_q, ovf_d;

  logic signed [PHASEWIDTH-1:0] delta;
  logic                         track;
  logic [GATEWIDTH-1:0]         len_next;
  logic                         win_end;
  logic signed [CalcWidth-1:0]  sum_raw, sum_sat, shifted;
  logic                         sat_hit;

  // prev follows the input in PRIME and RUN; in IDLE it is don't-care.
  assign track = enable_i && (state_q != StIdle);

  red_pitaya_pfd_unwrap #(
    .PHASEWIDTH (PHASEWIDTH)
  ) u_unwrap (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .load  (track),
    .phase (phase_i),
    .delta (delta)
  );

  always_comb begin
    len_next = (gate_len_i == '0) ? GATEWIDTH'(1) : gate_len_i;
    win_end  = (cnt_q == len_q - GATEWIDTH'(1));
    sum_raw  = CalcWidth'(acc_q) + CalcWidth'(delta);
    sum_sat  = saturate(sum_raw, ACCWIDTH);
    sat_hit  = (sum_sat != sum_raw);
    shifted  = sum_sat >>> shift_i;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    freq_d  = freq_q;
    out_d   = out_q;
    valid_d = 1'b0;
    // Clear first so a saturation in the same cycle wins.
    ovf_d   = ovf_q & ~clear_i;

    if (!enable_i) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StPrime;
        end
        StPrime: begin
          len_d   = len_next;
          state_d = StRun;
        end
        StRun: begin
          if (sat_hit) begin
            ovf_d = 1'b1;
          end
          if (win_end) begin
            freq_d  = ACCWIDTH'(sum_sat);
            out_d   = SIGNALBITS'(saturate(shifted, SIGNALBITS));
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            len_d   = len_next;
          end else begin
            acc_d = ACCWIDTH'(sum_sat);
            cnt_d = cnt_q + GATEWIDTH'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= GATEWIDTH'(1);
      freq_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      freq_q  <= freq_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign freq_o     = freq_q;
  assign out_o      = out_q;
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_red_pitaya_pfd_freq_meter.sv
// Self-checking bench for red_pitaya_pfd_freq_meter (16-bit accumulator build).
// The reference keeps the samples of the window in progress in a queue and
// closes a window once it holds gate_len steps past its reference sample.
module tb_red_pitaya_pfd_freq_meter;

  localparam int unsigned PW = 12;
  localparam int unsigned GW = 24;
  localparam int unsigned AW = 16;
  localparam int unsigned SB = 14;
  localparam longint AMAX = 32767;
  localparam longint AMIN = -32768;
  localparam longint OMAX = 8191;
  localparam longint OMIN = -8192;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [PW-1:0]        phase;
  logic                 en;
  logic [GW-1:0]        gl;
  logic [4:0]           sh;
  logic                 clr;
  logic signed [AW-1:0] freq;
  logic signed [SB-1:0] out;
  logic                 valid;
  logic                 ovf;

  always #5 clk = ~clk;

  red_pitaya_pfd_freq_meter #(
    .PHASEWIDTH (PW),
    .GATEWIDTH  (GW),
    .ACCWIDTH   (AW),
    .SIGNALBITS (SB)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .phase_i    (phase),
    .enable_i   (en),
    .gate_len_i (gl),
    .shift_i    (sh),
    .clear_i    (clr),
    .freq_o     (freq),
    .out_o      (out),
    .valid_o    (valid),
    .overflow_o (ovf)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  int     ph;
  int     en_run;
  int     win_q[$];
  int     win_len;
  longint m_sum;
  longint exp_freq, exp_out;
  logic   exp_valid, exp_ovf;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint unwrap_ref(input int cur, input int prv);
    int d;
    d = (cur - prv + 4096) % 4096;
    if (d >= 2048) d -= 4096;
    return longint'(d);
  endfunction

  function automatic longint clamp(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_reset();
    en_run = 0;
    win_q.delete();
    win_len = 1;
    m_sum = 0;
    exp_freq = 0;
    exp_out = 0;
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic compare_all(input string when);
    check_eq({when, ".valid"}, valid, exp_valid);
    check_eq({when, ".freq"}, freq, exp_freq);
    check_eq({when, ".out"}, out, exp_out);
    check_eq({when, ".ovf"}, ovf, exp_ovf);
  endtask

  // One clock edge: advance the reference with the inputs the DUT sampled, then compare.
  task automatic tick(input string when);
    longint s;
    int     cur;
    @(posedge clk);
    #1;
    cur = int'(phase);
    exp_valid = 1'b0;
    if (clr) exp_ovf = 1'b0;
    if (!en) begin
      en_run = 0;
      win_q.delete();
    end else begin
      if (en_run < 3) en_run++;
      if (en_run == 2) begin
        win_q.delete();
        win_q.push_back(cur);
        win_len = (gl == 0) ? 1 : int'(gl);
        m_sum = 0;
      end else if (en_run == 3) begin
        s = m_sum + unwrap_ref(cur, win_q[$]);
        if (s > AMAX || s < AMIN) exp_ovf = 1'b1;
        m_sum = clamp(s, AMIN, AMAX);
        win_q.push_back(cur);
        if (win_q.size() == win_len + 1) begin
          exp_freq  = m_sum;
          exp_out   = clamp(m_sum >>> sh, OMIN, OMAX);
          exp_valid = 1'b1;
          win_q.delete();
          win_q.push_back(cur);
          m_sum   = 0;
          win_len = (gl == 0) ? 1 : int'(gl);
        end
      end
    end
    compare_all(when);
  endtask

  task automatic seg(input string when, input int n, input int step);
    for (int i = 0; i < n; i++) begin
      ph = (ph + step + 4096) % 4096;
      phase = PW'(ph);
      tick(when);
    end
  endtask

  task automatic seg_rand(input string when, input int n, input bit rand_shift);
    for (int i = 0; i < n; i++) begin
      ph = int'($urandom_range(0, 4095));
      phase = PW'(ph);
      clr = ($urandom_range(0, 9) == 0);
      if (rand_shift) sh = 5'($urandom_range(0, 31));
      tick(when);
    end
    clr = 1'b0;
  endtask

  task automatic restart(input string when);
    en = 1'b0;
    seg(when, 2, 0);
    en = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b0;
    gl = '0;
    sh = '0;
    clr = 1'b0;
    ph = int'($urandom_range(0, 4095));
    phase = PW'(ph);
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // +3/cycle, 100-sample windows
    gl = 100; sh = 0; en = 1'b1;
    seg("inc3", 250, 3);

    // -5/cycle wrapping through zero
    restart("dec5_r"); gl = 50;
    seg("dec5", 120, -5);

    // Half-turn and just-under-half-turn steps
    restart("half_r"); gl = 4;
    seg("half", 20, 2048);
    seg("half_m1", 20, 2047);

    // Accumulator saturation, sticky overflow and clear
    restart("sat_r"); gl = 20;
    seg("sat", 45, 2047);
    seg("sat_hold", 30, 0);
    clr = 1'b1;
    seg("sat_clr", 1, 0);
    clr = 1'b0;
    seg("sat_after", 30, 0);

    // out_o saturation on a saturated window
    restart("osat_r"); gl = 100; sh = 0;
    seg("osat", 210, 2000);
    clr = 1'b1; seg("osat_clr", 1, 0); clr = 1'b0;

    // gate_len 0: window of one sample, random steps and shifts
    restart("g0_r"); gl = 0;
    seg_rand("g0", 40, 1'b1);
    sh = 0;

    // gate length changed mid-window
    restart("glchg_r"); gl = 100;
    seg("glchg_a", 30, 7);
    gl = 10;
    seg("glchg_b", 200, 7);

    // enable dropped mid-window, then a full window
    restart("endrop_r"); gl = 100;
    seg("endrop_a", 42, 1);
    en = 1'b0;
    seg("endrop_off", 3, 1);
    en = 1'b1;
    seg("endrop_b", 250, 1);

    // Random windows, shifts, clears and enable drops
    for (int r = 0; r < 8; r++) begin
      gl = GW'($urandom_range(0, 30));
      sh = 5'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      seg_rand("rand", 80, 1'b0);
    end

    // Reset asserted mid-window
    restart("rst_r"); gl = 100; sh = 0;
    seg("rst_pre", 150, 9);
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all("rst_mid");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    @(negedge clk);
    rstn = 1'b1;
    seg("rst_post", 120, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
